// File: rtl/lib_timer_pkg.sv
// Shared types and constants for the library seat timer.
package lib_timer_pkg;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'b00,
    CMD_RESERVE = 2'b01,
    CMD_EXTEND  = 2'b10,
    CMD_RELEASE = 2'b11
  } cmd_op_e;

  localparam int HOURS_PER_DAY = 24;
  localparam int MIN_PER_HOUR  = 60;
  localparam int HOUR_W        = 5;
  localparam int MIN_W         = 6;

  // True when the hour/minute pair is a legal time of day.
  function automatic logic time_in_range(input logic [HOUR_W-1:0] h,
                                         input logic [MIN_W-1:0]  m);
    return (h < HOUR_W'(HOURS_PER_DAY)) && (m < MIN_W'(MIN_PER_HOUR));
  endfunction

endpackage

// File: rtl/lib_seat_timer_seat_countdown.sv
// One seat channel: occupancy flag, remaining minutes and expiry pulse.
// Legality of commands is decided by the parent; this block only applies them.
module seat_countdown #(
  parameter int DUR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_clear,
  input  logic             i_reserve,
  input  logic             i_extend,
  input  logic             i_release,
  input  logic [DUR_W-1:0] i_dur,
  output logic             o_busy,
  output logic             o_expire
);

  localparam logic [DUR_W:0] SAT_MAX = {1'b0, {DUR_W{1'b1}}};

  logic             r_busy;
  logic [DUR_W-1:0] r_remain;
  logic             r_expire;
  logic [DUR_W:0]   w_sum;
  logic [DUR_W-1:0] w_ext;

  // Saturating remain + dur for extend.
  always_comb begin
    w_sum = {1'b0, r_remain} + {1'b0, i_dur};
    if (w_sum > SAT_MAX) begin
      w_ext = {DUR_W{1'b1}};
    end else begin
      w_ext = w_sum[DUR_W-1:0];
    end
  end

  // Seat state: closing clear wins, then the minute decrement, then commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_remain <= '0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= 1'b0;
      if (i_clear) begin
        r_busy   <= 1'b0;
        r_remain <= '0;
      end else if (i_tick) begin
        if (r_busy) begin
          if (r_remain <= DUR_W'(1)) begin
            r_busy   <= 1'b0;
            r_remain <= '0;
            r_expire <= 1'b1;
          end else begin
            r_remain <= r_remain - DUR_W'(1);
          end
        end
      end else if (i_reserve) begin
        r_busy   <= 1'b1;
        r_remain <= i_dur;
      end else if (i_extend) begin
        r_remain <= w_ext;
      end else if (i_release) begin
        r_busy   <= 1'b0;
        r_remain <= '0;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_expire = r_expire;

endmodule

// File: rtl/lib_seat_timer.sv
// Library time-of-day clock with per-seat occupancy countdowns and closing clear.
module lib_seat_timer
  import lib_timer_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60,
  parameter int N_SEATS       = 8,
  parameter int DUR_W         = 8,
  parameter int SEAT_W        = $clog2(N_SEATS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_valid,
  input  logic [4:0]         set_hour,
  input  logic [5:0]         set_min,
  input  logic [4:0]         close_hour,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [SEAT_W-1:0]  cmd_seat,
  input  logic [DUR_W-1:0]   cmd_dur,
  output logic               cmd_err,
  output logic [N_SEATS-1:0] seat_busy,
  output logic [N_SEATS-1:0] expire_pulse,
  output logic               close_pulse,
  output logic [4:0]         hour,
  output logic [5:0]         min,
  output logic [10:0]        time_out
);

  localparam int PRE_W = (TICKS_PER_MIN > 2) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MIN - 1);

  logic [PRE_W-1:0]  r_presc;
  logic [HOUR_W-1:0] r_hour;
  logic [MIN_W-1:0]  r_min;
  logic              r_close;
  logic              r_err;

  logic              w_min_tick;
  logic              w_set_ok;
  logic              w_set_bad;
  logic              w_tick;
  logic              w_close;
  logic [HOUR_W-1:0] w_next_hour;
  logic [MIN_W-1:0]  w_next_min;
  logic              w_cmd_fire;
  logic              w_seat_ok;
  logic              w_sel_busy;
  logic              w_cmd_bad;
  cmd_op_e           w_op;
  logic [N_SEATS-1:0] w_reserve_v;
  logic [N_SEATS-1:0] w_extend_v;
  logic [N_SEATS-1:0] w_release_v;
  logic [N_SEATS-1:0] w_busy_v;
  logic [N_SEATS-1:0] w_expire_v;
  logic [SEAT_W:0]    w_seat_ext;

  // Minute tick, time-load qualification and next time of day.
  always_comb begin
    w_min_tick = (r_presc == PRE_LAST);
    w_set_ok   = set_valid && time_in_range(set_hour, set_min);
    w_set_bad  = set_valid && !w_set_ok;
    // A valid time load restarts the minute, so it also suppresses this tick.
    w_tick     = w_min_tick && !w_set_ok;
    if (r_min == MIN_W'(MIN_PER_HOUR - 1)) begin
      w_next_min = '0;
      if (r_hour == HOUR_W'(HOURS_PER_DAY - 1)) begin
        w_next_hour = '0;
      end else begin
        w_next_hour = r_hour + HOUR_W'(1);
      end
    end else begin
      w_next_min  = r_min + MIN_W'(1);
      w_next_hour = r_hour;
    end
    // Closing only on a clock roll into close_hour:00, never on a load.
    w_close = w_tick && (w_next_min == '0) && (w_next_hour == close_hour);
  end

  // Command handshake and legality decode against the addressed seat.
  always_comb begin
    cmd_ready   = !w_min_tick;
    w_cmd_fire  = cmd_valid && cmd_ready;
    w_op        = cmd_op_e'(cmd_op);
    w_seat_ext  = {1'b0, cmd_seat};
    w_seat_ok   = (w_seat_ext < (SEAT_W+1)'(N_SEATS));
    w_reserve_v = '0;
    w_extend_v  = '0;
    w_release_v = '0;
    w_cmd_bad   = 1'b0;
    if (w_seat_ok) begin
      w_sel_busy = w_busy_v[cmd_seat];
    end else begin
      w_sel_busy = 1'b0;
    end
    if (w_cmd_fire) begin
      if (!w_seat_ok) begin
        w_cmd_bad = (w_op != CMD_NOP);
      end else begin
        case (w_op)
          CMD_RESERVE: begin
            if (w_sel_busy || (cmd_dur == '0)) begin
              w_cmd_bad = 1'b1;
            end else begin
              w_reserve_v[cmd_seat] = 1'b1;
            end
          end
          CMD_EXTEND: begin
            if (w_sel_busy) begin
              w_extend_v[cmd_seat] = 1'b1;
            end else begin
              w_cmd_bad = 1'b1;
            end
          end
          CMD_RELEASE: begin
            if (w_sel_busy) begin
              w_release_v[cmd_seat] = 1'b1;
            end else begin
              w_cmd_bad = 1'b0;
            end
          end
          CMD_NOP: w_cmd_bad = 1'b0;
          default: w_cmd_bad = 1'b0;
        endcase
      end
    end else begin
      w_cmd_bad = 1'b0;
    end
  end

  // Prescaler, time of day, and the registered error / closing pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_hour  <= '0;
      r_min   <= '0;
      r_close <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err   <= w_set_bad || w_cmd_bad;
      r_close <= w_close;
      if (w_set_ok) begin
        r_hour  <= set_hour;
        r_min   <= set_min;
        r_presc <= '0;
      end else if (w_min_tick) begin
        r_hour  <= w_next_hour;
        r_min   <= w_next_min;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PRE_W'(1);
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_SEATS; g++) begin : g_seat
      seat_countdown #(.DUR_W(DUR_W)) u_seat (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (w_tick),
        .i_clear   (w_close),
        .i_reserve (w_reserve_v[g]),
        .i_extend  (w_extend_v[g]),
        .i_release (w_release_v[g]),
        .i_dur     (cmd_dur),
        .o_busy    (w_busy_v[g]),
        .o_expire  (w_expire_v[g])
      );
    end
  endgenerate

  assign seat_busy    = w_busy_v;
  assign expire_pulse = w_expire_v;
  assign close_pulse  = r_close;
  assign cmd_err      = r_err;
  assign hour         = r_hour;
  assign min          = r_min;
  assign time_out     = {r_hour, r_min};

endmodule

// File: tb/tb_lib_seat_timer.sv
// Directed bench for lib_seat_timer with TICKS_PER_MIN=4, N_SEATS=4, DUR_W=4.
module tb_lib_seat_timer;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RES = 2'b01;
  localparam logic [1:0] OP_EXT = 2'b10;
  localparam logic [1:0] OP_REL = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_valid;
  logic [4:0]  set_hour;
  logic [5:0]  set_min;
  logic [4:0]  close_hour;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_seat;
  logic [3:0]  cmd_dur;
  logic        cmd_err;
  logic [3:0]  seat_busy;
  logic [3:0]  expire_pulse;
  logic        close_pulse;
  logic [4:0]  hour_o;
  logic [5:0]  min_o;
  logic [10:0] time_o;

  int n_cmp = 0;
  int n_bad = 0;

  lib_seat_timer #(.TICKS_PER_MIN(4), .N_SEATS(4), .DUR_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .set_valid    (set_valid),
    .set_hour     (set_hour),
    .set_min      (set_min),
    .close_hour   (close_hour),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_seat     (cmd_seat),
    .cmd_dur      (cmd_dur),
    .cmd_err      (cmd_err),
    .seat_busy    (seat_busy),
    .expire_pulse (expire_pulse),
    .close_pulse  (close_pulse),
    .hour         (hour_o),
    .min          (min_o),
    .time_out     (time_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m);
    set_valid = 1'b1;
    set_hour  = h;
    set_min   = m;
    step();
    set_valid = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [1:0] s, input logic [3:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_seat  = s;
    cmd_dur   = d;
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  initial begin
    set_valid  = 1'b0;
    set_hour   = 5'd0;
    set_min    = 6'd0;
    close_hour = 5'd9;
    cmd_valid  = 1'b0;
    cmd_op     = OP_NOP;
    cmd_seat   = 2'd0;
    cmd_dur    = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_hour", hour_o, 32'd0);
    chk("rst_min", min_o, 32'd0);
    chk("rst_time", time_o, 32'd0);
    chk("rst_busy", seat_busy, 32'd0);
    chk("rst_expire", expire_pulse, 32'd0);
    chk("rst_close", close_pulse, 32'd0);
    chk("rst_err", cmd_err, 32'd0);
    chk("rst_ready", cmd_ready, 32'd1);

    // Free-running hour
    for (int i = 1; i <= 240; i++) begin
      step();
      chk("run_min", min_o, 32'((i / 4) % 60));
      chk("run_ready", cmd_ready, ((i % 4) != 3) ? 32'd1 : 32'd0);
    end
    chk("run_hour", hour_o, 32'd1);
    chk("run_min_end", min_o, 32'd0);

    // Day wrap from 23:59
    set_time(5'd23, 6'd59);
    chk("load_time", time_o, 32'd1531);
    repeat (3) step();
    chk("pre_wrap_min", min_o, 32'd59);
    step();
    chk("wrap_hour", hour_o, 32'd0);
    chk("wrap_min", min_o, 32'd0);

    // Out-of-range loads
    set_time(5'd24, 6'd0);
    chk("bad_hour_err", cmd_err, 32'd1);
    chk("bad_hour_time", time_o, 32'd0);
    step();
    chk("bad_hour_err_end", cmd_err, 32'd0);
    set_time(5'd10, 6'd60);
    chk("bad_min_err", cmd_err, 32'd1);
    chk("bad_min_time", time_o, 32'd0);
    step();
    chk("bad_min_tick", min_o, 32'd1);

    // Reserve seat 2 for 3 minutes, expiry on the third tick
    set_time(5'd10, 6'd0);
    cmd(OP_RES, 2'd2, 4'd3);
    chk("res_busy", seat_busy, 32'd4);
    chk("res_err", cmd_err, 32'd0);
    for (int e = 2; e <= 13; e++) begin
      step();
      chk("exp_pulse", expire_pulse, (e == 12) ? 32'd4 : 32'd0);
      chk("exp_busy", seat_busy, (e < 12) ? 32'd4 : 32'd0);
    end

    // Errors and extend saturation
    set_time(5'd11, 6'd0);
    cmd(OP_RES, 2'd2, 4'd10);
    chk("res10_busy", seat_busy, 32'd4);
    cmd(OP_EXT, 2'd2, 4'd10);
    chk("ext_err", cmd_err, 32'd0);
    cmd(OP_RES, 2'd2, 4'd5);
    chk("res_busy_err", cmd_err, 32'd1);
    chk("tick_not_ready", cmd_ready, 32'd0);
    step();
    chk("err_clear", cmd_err, 32'd0);
    chk("min_11_01", min_o, 32'd1);
    cmd(OP_EXT, 2'd1, 4'd3);
    chk("ext_idle_err", cmd_err, 32'd1);
    chk("ext_idle_busy", seat_busy, 32'd4);
    cmd(OP_REL, 2'd0, 4'd0);
    chk("rel_idle_err", cmd_err, 32'd0);
    cmd(OP_RES, 2'd1, 4'd0);
    chk("res_zero_err", cmd_err, 32'd1);
    chk("res_zero_busy", seat_busy, 32'd4);
    for (int e = 8; e <= 61; e++) begin
      step();
      chk("sat_pulse", expire_pulse, (e == 60) ? 32'd4 : 32'd0);
    end
    chk("sat_busy_end", seat_busy, 32'd0);

    // Release a busy seat: no expiry afterwards
    set_time(5'd12, 6'd0);
    cmd(OP_RES, 2'd1, 4'd1);
    chk("rel_pre_busy", seat_busy, 32'd2);
    cmd(OP_REL, 2'd1, 4'd0);
    chk("rel_busy", seat_busy, 32'd0);
    chk("rel_err", cmd_err, 32'd0);
    step();
    step();
    chk("rel_no_pulse", expire_pulse, 32'd0);

    // Loading close_hour:00 does not close
    set_time(5'd9, 6'd0);
    chk("load_close_hr", hour_o, 32'd9);
    for (int e = 1; e <= 4; e++) begin
      chk("load_no_close", close_pulse, 32'd0);
      step();
    end
    chk("load_no_close_end", close_pulse, 32'd0);

    // Closing clears seats, suppressing expiry
    set_time(5'd8, 6'd59);
    cmd(OP_RES, 2'd0, 4'd5);
    cmd(OP_RES, 2'd3, 4'd1);
    chk("close_pre_busy", seat_busy, 32'd9);
    step();
    chk("close_pre_pulse", close_pulse, 32'd0);
    step();
    chk("close_pulse", close_pulse, 32'd1);
    chk("close_busy", seat_busy, 32'd0);
    chk("close_expire", expire_pulse, 32'd0);
    chk("close_time", time_o, 32'd576);
    step();
    chk("close_pulse_end", close_pulse, 32'd0);
    chk("close_expire_end", expire_pulse, 32'd0);

    // Asynchronous reset mid-countdown
    set_time(5'd5, 6'd30);
    cmd(OP_RES, 2'd1, 4'd3);
    step();
    chk("arst_pre_busy", seat_busy, 32'd2);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", seat_busy, 32'd0);
    chk("arst_time", time_o, 32'd0);
    chk("arst_ready", cmd_ready, 32'd1);
    step();
    step();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk("post_rst_expire", expire_pulse, 32'd0);
      chk("post_rst_close", close_pulse, 32'd0);
      chk("post_rst_busy", seat_busy, 32'd0);
      chk("post_rst_min", min_o, 32'(e / 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lib_seat_timer.md
# lib_seat_timer

Parametrised library time-of-day clock and per-seat occupancy timer for the seating system. It runs a prescaled hour/minute clock with correct 0–23 and 0–59 wrap, and loads, extends and releases per-seat countdowns through a ready/valid command port. It flags each seat expiry with a one-cycle pulse and clears every seat at a programmable closing hour. It sits between the seat-reservation controller and the display/status logic.

## Interface
Parameters:
- TICKS_PER_MIN, 60: clk cycles per minute tick; must be ≥ 2.
- N_SEATS, 8: number of seat channels; must be ≥ 2.
- DUR_W, 8: width of a seat duration in minutes. Maximum duration is 2^DUR_W−1.
- SEAT_W, $clog2(N_SEATS): derived; do not override.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- set_valid  in  1  load time of day this cycle
- set_hour  in  5  hour to load, 0–23
- set_min  in  6  minute to load, 0–59
- close_hour  in  5  closing hour, static between uses
- cmd_valid  in  1  seat command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 nop, 01 reserve, 10 extend, 11 release
- cmd_seat  in  SEAT_W  target seat
- cmd_dur  in  DUR_W  minutes for reserve/extend
- cmd_err  out  1  one-cycle pulse: accepted command rejected
- seat_busy  out  N_SEATS  seat occupied
- expire_pulse  out  N_SEATS  one-cycle pulse when a seat countdown reaches 0
- close_pulse  out  1  one-cycle pulse at closing
- hour  out  5  current hour
- min  out  6  current minute
- time_out  out  11  {hour, min}

## Operation
- Prescaler: counts 0..TICKS_PER_MIN−1. min_tick is the cycle in which prescaler == TICKS_PER_MIN−1; the prescaler wraps to 0 in the next cycle.
- Clock on min_tick:
  - min 59→0 and hour increments.
  - hour 23→0.
- set_valid:
  - In range: loads hour/min and clears the prescaler. This overrides the min_tick time update in the same cycle.
  - Out of range (hour>23 or min>59): ignored, and cmd_err pulses.
- Seat countdowns (remain, DUR_W bits each) decrement on min_tick while busy.
  - remain 1→0 clears busy and pulses expire_pulse[seat].
- Commands (cmd_seat ≥ N_SEATS → cmd_err):
  - reserve: idle seat and dur≠0 → busy=1, remain=dur. Busy seat or dur=0 → cmd_err, no change.
  - extend: busy seat → remain = min(remain+dur, 2^DUR_W−1). Idle seat → cmd_err.
  - release: busy seat → busy=0, remain=0, no expire pulse. Idle seat → no-op, no error.
  - nop: no effect, no error.
- Closing: on min_tick where the clock rolls to close_hour:00, close_pulse fires and all seats clear to idle. No expire_pulse fires for seats cleared this way, including seats that would have expired on that tick.
- Clock-load behaviour:
  - A set_valid that loads close_hour:00 does not trigger closing.
  - After a time load, expiry countdowns restart from a fresh full minute.
- cmd_ready = 0 in the min_tick cycle; otherwise 1. This keeps commands and decrements in separate cycles.

## Timing
- All outputs are registered except cmd_ready, which is a decode of the prescaler.
- Reset values: hour=0, min=0, seat_busy=0, all remain=0, expire_pulse=0, close_pulse=0, cmd_err=0, prescaler=0, cmd_ready=1.
- An accepted command at edge N is visible on seat_busy, and cmd_err pulses, in the cycle after edge N.
- Clock and countdown updates from min_tick at edge N are visible after edge N. expire_pulse and close_pulse are high for exactly that one cycle.
- A rst assertion mid-countdown clears all state immediately, with no pulses. Counting restarts from prescaler 0 after release.

## Structure
- Package lib_timer_pkg:
  - cmd_op_e enum (CMD_NOP, CMD_RESERVE, CMD_EXTEND, CMD_RELEASE)
  - HOURS_PER_DAY=24, MIN_PER_HOUR=60
  - HOUR_W=5, MIN_W=6
- Sub-module seat_countdown holds one seat's busy/remain/expire logic. It is instantiated N_SEATS times via generate. Top level holds the prescaler, time of day, closing detect and command decode.

## Test plan
(TICKS_PER_MIN=4, N_SEATS=4, DUR_W=4)
- Reset, then run 240 cycles → min=0→59 over 236 cycles; hour=1, min=0 after cycle 240. cmd_ready low every 4th cycle.
- Set 23:59 → after 4 cycles hour=0, min=0. Set 24:00 → cmd_err pulses, time unchanged.
- Reserve seat 2 for 3 min → busy[2]=1 next cycle; expire_pulse[2] on the 3rd min_tick; busy[2]=0 after.
- Reserve busy seat 2 → cmd_err. Reserve with dur 0 → cmd_err. Extend seat 2 (remain 10) by 10 → remain saturates at 15. Extend idle seat 1 → cmd_err.
- close_hour=9, set 8:59, seats 0 and 3 busy (seat 3 remain=1) → at next tick close_pulse=1, seat_busy=0, expire_pulse stays 0.
- Assert rst with seat 1 mid-countdown → seat_busy=0 and time=0:00 asynchronously; no pulses follow.
